// File: rtl/axi4lite_ammrt_bridge_if.sv
// Avalon-MM signal bundle driven by the AXI4-Lite bridge (master) toward
// register banks and memories (slave).
interface ammrt_if #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4
);
  logic [P_ASIZE-1:0]    address;
  logic                  read;
  logic                  write;
  logic [P_DBYTES*8-1:0] writedata;
  logic [P_DBYTES-1:0]   byteenable;
  logic                  waitrequest;
  logic [P_DBYTES*8-1:0] readdata;
  logic                  readdatavalid;

  modport master (output address, read, write, writedata, byteenable,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/axi4lite_ammrt_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge, one transaction in flight,
// pipelined reads with an optional readdatavalid timeout returning SLVERR.
module axi4lite_ammrt_bridge #(
  parameter int P_ASIZE   = 32,
  parameter int P_DBYTES  = 4,
  parameter int P_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_ASIZE-1:0]    s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [P_DBYTES*8-1:0] s_wdata,
  input  logic [P_DBYTES-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [P_ASIZE-1:0]    s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [P_DBYTES*8-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  ammrt_if.master               avm
);
  localparam int DW      = P_DBYTES * 8;
  localparam int CW      = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam int TO_LAST = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_RSP, RD_CMD, RD_WAIT, RD_RSP} state_e;

  typedef struct packed {
    logic [P_ASIZE-1:0]  addr;
    logic [DW-1:0]       data;
    logic [P_DBYTES-1:0] strb;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_rd_q, last_rd_d;
  logic          wr_cand, rd_cand, pick_wr, timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      cnt_q     <= '0;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign wr_cand     = s_awvalid && s_wvalid;
  assign rd_cand     = s_arvalid;
  // Contested cycle alternates; last_rd resets high so a write goes first.
  assign pick_wr     = wr_cand && (!rd_cand || last_rd_q);
  assign timeout_hit = (P_TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          s_awready  = 1'b1;
          s_wready   = 1'b1;
          cmd_d.addr = s_awaddr;
          cmd_d.data = s_wdata;
          cmd_d.strb = s_wstrb;
          last_rd_d  = 1'b0;
          state_d    = WR_CMD;
        end else if (rd_cand) begin
          s_arready  = 1'b1;
          cmd_d.addr = s_araddr;
          last_rd_d  = 1'b1;
          state_d    = RD_CMD;
        end
      end
      WR_CMD: if (!avm.waitrequest) state_d = WR_RSP;
      WR_RSP: if (s_bready) state_d = IDLE;
      RD_CMD: begin
        if (!avm.waitrequest) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm.readdatavalid) begin
          rdata_d = avm.readdata;
          rresp_d = 2'b00;
          state_d = RD_RSP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          rresp_d = 2'b10;
          state_d = RD_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_RSP: if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_bresp  = 2'b00;
  assign s_bvalid = (state_q == WR_RSP);
  assign s_rvalid = (state_q == RD_RSP);
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  // Command fields come straight from the capture register, so they stay
  // stable for the whole waitrequest stall.
  assign avm.address    = cmd_q.addr;
  assign avm.writedata  = cmd_q.data;
  assign avm.write      = (state_q == WR_CMD);
  assign avm.read       = (state_q == RD_CMD);
  assign avm.byteenable = (state_q == WR_CMD) ? cmd_q.strb :
                          (state_q == RD_CMD) ? {P_DBYTES{1'b1}} : '0;
endmodule

// File: tb/tb_axi4lite_ammrt_bridge.sv
// Scenario bench for the AXI4-Lite to Avalon-MM bridge with a scripted
// Avalon slave and scoreboard queues for Avalon commands and AXI responses.
module tb_axi4lite_ammrt_bridge;
  localparam int AW = 32, DB = 4, DW = 32, TO = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DB-1:0] s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_bvalid, s_bready, s_rvalid, s_rready;

  always #5 clk = ~clk;

  ammrt_if #(.P_ASIZE(AW), .P_DBYTES(DB)) avm_if ();

  axi4lite_ammrt_bridge #(.P_ASIZE(AW), .P_DBYTES(DB), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .avm(avm_if)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [DB-1:0] be; } wr_exp_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rd_exp_t;

  wr_exp_t       exp_wr[$];
  logic [AW-1:0] exp_ra[$];
  logic [1:0]    exp_b[$];
  rd_exp_t       exp_r[$];
  int checks = 0, errors = 0;

  int            cfg_ws = 0, cfg_lat = 1;
  bit            cfg_rd_never = 1'b0;
  logic [DW-1:0] cfg_rdata = '0;

  function automatic logic [110:0] all_outs();
    return {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata,
            avm_if.read, avm_if.write, avm_if.address, avm_if.writedata, avm_if.byteenable};
  endfunction

  // Avalon slave: cfg_ws waitstates per command, readdatavalid cfg_lat cycles
  // after read acceptance; accepted commands are checked against the scoreboard.
  initial begin : slave_model
    int ws, rd_cnt;
    bit rd_pend;
    wr_exp_t ew;
    logic [AW-1:0] ea;
    ws = 0; rd_cnt = 0; rd_pend = 1'b0;
    avm_if.waitrequest = 1'b0; avm_if.readdatavalid = 1'b0; avm_if.readdata = '0;
    forever begin
      @(posedge clk); #2;
      avm_if.readdatavalid = 1'b0;
      if (!rst_n) begin
        ws = 0; rd_pend = 1'b0; avm_if.waitrequest = 1'b0;
      end else begin
        if (rd_pend) begin
          rd_cnt--;
          if (rd_cnt <= 0) begin
            rd_pend = 1'b0; avm_if.readdatavalid = 1'b1; avm_if.readdata = cfg_rdata;
          end
        end
        if (avm_if.write || avm_if.read) begin
          if (ws < cfg_ws) begin
            avm_if.waitrequest = 1'b1; ws++;
          end else begin
            avm_if.waitrequest = 1'b0; ws = 0;
            checks++;
            if (avm_if.write) begin
              if (exp_wr.size() == 0) begin
                errors++; $display("FAIL avm_write: unexpected write addr=%h", avm_if.address);
              end else begin
                ew = exp_wr.pop_front();
                if ({avm_if.address, avm_if.writedata, avm_if.byteenable} !== {ew.addr, ew.data, ew.be}) begin
                  errors++;
                  $display("FAIL avm_write: got addr=%h data=%h be=%h, want addr=%h data=%h be=%h",
                           avm_if.address, avm_if.writedata, avm_if.byteenable, ew.addr, ew.data, ew.be);
                end
              end
            end else begin
              if (exp_ra.size() == 0) begin
                errors++; $display("FAIL avm_read: unexpected read addr=%h", avm_if.address);
              end else begin
                ea = exp_ra.pop_front();
                if ({avm_if.address, avm_if.byteenable} !== {ea, 4'hF}) begin
                  errors++;
                  $display("FAIL avm_read: got addr=%h be=%h, want addr=%h be=f",
                           avm_if.address, avm_if.byteenable, ea);
                end
              end
              if (!cfg_rd_never) begin rd_pend = 1'b1; rd_cnt = cfg_lat; end
            end
          end
        end else begin
          avm_if.waitrequest = 1'b0; ws = 0;
        end
      end
    end
  end

  logic [1:0] mon_b;
  rd_exp_t    mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_bvalid && s_bready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++; $display("FAIL bresp: unexpected response bresp=%b", s_bresp);
        end else begin
          mon_b = exp_b.pop_front();
          if (s_bresp !== mon_b) begin
            errors++; $display("FAIL bresp: got %b want %b", s_bresp, mon_b);
          end
        end
      end
      if (s_rvalid && s_rready) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++; $display("FAIL rresp: unexpected response rdata=%h rresp=%b", s_rdata, s_rresp);
        end else begin
          mon_r = exp_r.pop_front();
          if ({s_rdata, s_rresp} !== {mon_r.data, mon_r.resp}) begin
            errors++;
            $display("FAIL rresp: got rdata=%h rresp=%b want rdata=%h rresp=%b",
                     s_rdata, s_rresp, mon_r.data, mon_r.resp);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DB-1:0] s);
    bit got;
    exp_wr.push_back('{a, d, s});
    exp_b.push_back(2'b00);
    @(posedge clk); #1;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = s_awready && s_wready; end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL write_accept: addr=%h not accepted in 20 cycles", a); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = s_bvalid; end
    checks++;
    if (!got) begin errors++; $display("FAIL write_resp: no bvalid for addr=%h in 20 cycles", a); end
  endtask

  // Returns edges from Avalon read acceptance to the rise of s_rvalid (-1 if none).
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] slave_d,
                         input logic [DW-1:0] exp_d, input logic [1:0] exp_resp, output int lat);
    bit got;
    int n;
    cfg_rdata = slave_d;
    exp_ra.push_back(a);
    exp_r.push_back('{exp_d, exp_resp});
    lat = -1;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = s_arready; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL read_accept: addr=%h not accepted in 20 cycles", a); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = avm_if.read && !avm_if.waitrequest; end
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin @(negedge clk); n++; got = s_rvalid; end
    checks++;
    if (!got) begin errors++; $display("FAIL read_resp: no rvalid for addr=%h in 40 cycles", a); end
    else lat = n - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL idle_outputs: got %h want 0", all_outs()); end
  endtask

  task automatic test_single_write();
    cfg_ws = 0; s_bready = 1'b1;
    exp_wr.push_back('{32'h10, 32'hDEADBEEF, 4'hF});
    exp_b.push_back(2'b00);
    @(posedge clk); #1;
    s_awaddr = 32'h10; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_awready, s_wready} !== 2'b11) begin
      errors++; $display("FAIL wr_handshake: awready/wready=%b want 11", {s_awready, s_wready});
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({avm_if.write, s_bvalid, avm_if.address, avm_if.writedata, avm_if.byteenable} !==
        {1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++;
      $display("FAIL wr_cmd_cycle: write=%b bvalid=%b addr=%h data=%h be=%h want 1 0 10 deadbeef f",
               avm_if.write, s_bvalid, avm_if.address, avm_if.writedata, avm_if.byteenable);
    end
    @(negedge clk);
    checks++;
    if ({avm_if.write, s_bvalid, s_bresp} !== 4'b0100) begin
      errors++; $display("FAIL wr_rsp_cycle: write=%b bvalid=%b bresp=%b want 0 1 00",
                         avm_if.write, s_bvalid, s_bresp);
    end
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL wr_rsp_clear: bvalid=%b want 0", s_bvalid); end
  endtask

  task automatic test_write_waitstates();
    int wcnt;
    bit done, got, unstable, busy_acc;
    cfg_ws = 3; s_bready = 1'b1;
    exp_wr.push_back('{32'h44, 32'hA5A55A5A, 4'h3});
    exp_b.push_back(2'b00);
    @(posedge clk); #1;
    s_awaddr = 32'h44; s_wdata = 32'hA5A55A5A; s_wstrb = 4'h3; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    // A second write stays presented while the first is stalled.
    s_awaddr = 32'h48; s_wdata = 32'h11223344; s_wstrb = 4'hC;
    exp_wr.push_back('{32'h48, 32'h11223344, 4'hC});
    exp_b.push_back(2'b00);
    wcnt = 0; done = 1'b0; unstable = 1'b0; busy_acc = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (avm_if.write) begin
        wcnt++;
        if ({avm_if.address, avm_if.writedata, avm_if.byteenable} !== {32'h44, 32'hA5A55A5A, 4'h3})
          unstable = 1'b1;
      end
      if (s_awready || s_wready || s_arready) busy_acc = 1'b1;
      done = s_bvalid;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL ws_resp: bvalid=0 want 1 within 20 cycles"); end
    checks++;
    if (wcnt != 4) begin errors++; $display("FAIL ws_write_cycles: got %0d want 4", wcnt); end
    checks++;
    if (unstable) begin errors++; $display("FAIL ws_stable: command changed=1 want 0"); end
    checks++;
    if (busy_acc) begin errors++; $display("FAIL ws_busy_accept: ready while busy=1 want 0"); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = s_awready && s_wready; end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL ws_second_accept: accepted=0 want 1"); end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin @(negedge clk); done = s_bvalid; end
    checks++;
    if (!done) begin errors++; $display("FAIL ws_second_resp: bvalid=0 want 1"); end
    cfg_ws = 0;
  endtask

  task automatic test_read_latency();
    int lat;
    cfg_lat = 5; s_rready = 1'b0;
    do_read(32'h20, 32'h12345678, 32'h12345678, 2'b00, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL rd_latency: got %0d want 5", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 32'h12345678, 2'b00}) begin
        errors++; $display("FAIL rd_hold: rvalid=%b rdata=%h rresp=%b want 1 12345678 00",
                           s_rvalid, s_rdata, s_rresp);
      end
    end
    @(posedge clk); #1 s_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_rvalid !== 1'b0) begin errors++; $display("FAIL rd_clear: rvalid=%b want 0", s_rvalid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    cfg_lat = 1; s_bready = 1'b1; s_rready = 1'b1;
    do_write(32'h13, 32'h0000BEEF, 4'h0);
    do_read(32'h13, 32'h76543210, 32'h76543210, 2'b00, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL b2b_rd_latency: got %0d want 1", lat); end
    do_write(32'hFFFFFFFC, 32'hFFFF0000, 4'h9);
  endtask

  task automatic test_contention();
    int grants;
    bit order_ok;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_lat = 2; cfg_ws = 0; s_bready = 1'b1; s_rready = 1'b1; cfg_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    s_awaddr = 32'h60; s_wdata = 32'h600D600D; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h64; s_arvalid = 1'b1;
    grants = 0; order_ok = 1'b1;
    for (int i = 0; i < 80 && grants < 4; i++) begin
      @(negedge clk);
      if (s_awready && s_wready) begin
        if (grants % 2 != 0) order_ok = 1'b0;
        exp_wr.push_back('{32'h60, 32'h600D600D, 4'hF});
        exp_b.push_back(2'b00);
        grants++;
      end else if (s_arready) begin
        if (grants % 2 != 1) order_ok = 1'b0;
        exp_ra.push_back(32'h64);
        exp_r.push_back('{32'h5555AAAA, 2'b00});
        grants++;
      end
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    checks++;
    if (grants != 4) begin errors++; $display("FAIL arb_grants: got %0d want 4", grants); end
    checks++;
    if (!order_ok) begin errors++; $display("FAIL arb_order: alternating W,R,W,R=0 want 1"); end
    for (int i = 0; i < 40 && (exp_b.size() + exp_r.size()) != 0; i++) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    s_rready = 1'b1; cfg_rd_never = 1'b1;
    do_read(32'h30, 32'h0, 32'h0, 2'b10, lat);
    checks++;
    if (lat != TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO); end
    @(negedge clk);
    cfg_rd_never = 1'b0; cfg_lat = 3;
    do_read(32'h34, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL post_timeout_latency: got %0d want 3", lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int lat;
    bit got;
    s_rready = 1'b1; cfg_rd_never = 1'b1;
    exp_ra.push_back(32'h08);
    @(posedge clk); #1;
    s_araddr = 32'h08; s_arvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = s_arready; end
    @(posedge clk); #1 s_arvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL midrst_accept: accepted=0 want 1"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL midrst_async: got %h want 0", all_outs()); end
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL midrst_held: got %h want 0", all_outs()); end
    @(posedge clk); #1 rst_n = 1'b1;
    cfg_rd_never = 1'b0; cfg_lat = 2;
    repeat (2) @(negedge clk);
    do_read(32'h04, 32'h0BADF00D, 32'h0BADF00D, 2'b00, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL midrst_next_read: latency %0d want 2", lat); end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_write_waitstates();
    test_read_latency();
    test_back_to_back();
    test_contention();
    test_timeout();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    checks++;
    if ((exp_wr.size() + exp_ra.size() + exp_b.size() + exp_r.size()) != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending wr=%0d ra=%0d b=%0d r=%0d want all 0",
               exp_wr.size(), exp_ra.size(), exp_b.size(), exp_r.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
